cpu_trace_buffer: RTL

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

---
 rtl/cpu_trace_buffer_pkg.sv | 31 +++
 rtl/trace_fifo_mem.sv | 42 ++++
 rtl/cpu_trace_buffer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_buffer_pkg.sv
// Shared definitions for the CPU retirement trace buffer: FSM encodings,
// trace entry layout, flag bit positions and the default buffer depth.
// Optional feature macro: TRACE_TRIGGER_EN (adds the ARMED state / PC trigger).
package cpu_trace_buffer_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned STATE_W         = 2;
  localparam int unsigned FLAG_W          = 2;
  localparam int unsigned TRACE_DEPTH_DEF = 16;

  // Bit positions inside the {RegWrite, MemWrite} flag field
  localparam int unsigned FLAG_REGWR = 1;
  localparam int unsigned FLAG_MEMWR = 0;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
`ifdef TRACE_TRIGGER_EN
    ST_ARMED   = 2'd1,
`endif
    ST_CAPTURE = 2'd2,
    ST_FULL    = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   alu;
    logic [FLAG_W-1:0] flags;
  } trace_entry_t;

endpackage : cpu_trace_buffer_pkg

// File: rtl/trace_fifo_mem.sv
// Trace entry storage with wrapping read/write pointers.
// Write port is synchronous; read port shows the head entry combinationally.
module trace_fifo_mem
  import cpu_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_wr_en,
  input  trace_entry_t i_wr_data,
  input  logic         i_rd_en,
  output trace_entry_t o_rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;

  // Storage write; contents are not reset, only the pointers are
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];

endmodule : trace_fifo_mem

// File: rtl/cpu_trace_buffer.sv
// Captures retired instructions from a single-cycle core into a FWFT trace
// FIFO. IDLE -> CAPTURE on arm, CAPTURE -> FULL when the buffer fills,
// FULL -> IDLE once drained. Retirements seen while FULL set a sticky flag.
// Optional feature macro: TRACE_TRIGGER_EN -- arming enters ARMED, which waits
// for a retirement at iTrigPC before capture starts.
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   iValid,
  input  logic [XLEN-1:0]        iPC,
  input  logic [XLEN-1:0]        iInstruction,
  input  logic [XLEN-1:0]        iAluResult,
  input  logic                   iRegWrite,
  input  logic                   iMemWrite,
  input  logic                   iArm,
`ifdef TRACE_TRIGGER_EN
  input  logic [XLEN-1:0]        iTrigPC,
`endif
  input  logic                   iRdReady,
  output logic                   oRdValid,
  output logic [XLEN-1:0]        oRdPC,
  output logic [XLEN-1:0]        oRdInstruction,
  output logic [XLEN-1:0]        oRdAluResult,
  output logic [FLAG_W-1:0]      oRdFlags,
  output logic [STATE_W-1:0]     oState,
  output logic [$clog2(DEPTH):0] oCount,
  output logic                   oOverflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e       r_state;
  state_e       w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_overflow;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  trace_entry_t  w_wr_data;
  trace_entry_t  w_rd_data;

`ifdef TRACE_TRIGGER_EN
  logic w_trig_hit;
  assign w_trig_hit = iValid && (iPC == iTrigPC);
`endif

  // Pop whenever the consumer takes a valid head, regardless of state
  assign w_pop       = (r_count != '0) && iRdReady;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iArm) begin
`ifdef TRACE_TRIGGER_EN
          w_state_nxt = ST_ARMED;
`else
          w_state_nxt = ST_CAPTURE;
`endif
        end
      end
`ifdef TRACE_TRIGGER_EN
      ST_ARMED: begin
        if (w_trig_hit) w_state_nxt = ST_CAPTURE;
      end
`endif
      ST_CAPTURE: begin
        if (w_push && (w_count_nxt == CW'(DEPTH))) w_state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (w_count_nxt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control outputs: push enable and overflow set/clear
  always_comb begin
    w_push    = 1'b0;
    w_ovf_set = 1'b0;
    w_ovf_clr = 1'b0;
    case (r_state)
      ST_IDLE:    w_ovf_clr = iArm;
`ifdef TRACE_TRIGGER_EN
      ST_ARMED:   w_push    = w_trig_hit;
`endif
      ST_CAPTURE: w_push    = iValid;
      ST_FULL:    w_ovf_set = iValid;
      default:    ;
    endcase
  end

  // Occupancy counter; CAPTURE leaves for FULL before it could exceed DEPTH
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // Sticky overflow: set by retirements lost while FULL, cleared on arm
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end
  end

  // Pack the retirement record into a trace entry
  always_comb begin
    w_wr_data                  = '0;
    w_wr_data.pc               = iPC;
    w_wr_data.instr            = iInstruction;
    w_wr_data.alu              = iAluResult;
    w_wr_data.flags[FLAG_REGWR] = iRegWrite;
    w_wr_data.flags[FLAG_MEMWR] = iMemWrite;
  end

  trace_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_wr_en   (w_push),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data)
  );

  assign oRdValid       = (r_count != '0);
  assign oRdPC          = w_rd_data.pc;
  assign oRdInstruction = w_rd_data.instr;
  assign oRdAluResult   = w_rd_data.alu;
  assign oRdFlags       = w_rd_data.flags;
  assign oState         = r_state;
  assign oCount         = r_count;
  assign oOverflow      = r_overflow;

endmodule : cpu_trace_buffer
